// File: rtl/uart_alu_pkg.sv
// Shared types and defaults for the UART-driven ALU controller.
package uart_alu_pkg;

  localparam int unsigned NB_DATA_DEF       = 8;
  localparam int unsigned NB_OP_DEF         = 6;
  // 4 frames of 10 bits at 16 ticks per bit
  localparam int unsigned TIMEOUT_TICKS_DEF = 640;
  localparam int unsigned TMR_W             = 16;

  // One-hot controller states
  typedef enum logic [4:0] {
    StWaitA  = 5'b00001,
    StWaitB  = 5'b00010,
    StWaitOp = 5'b00100,
    StExec   = 5'b01000,
    StWaitTx = 5'b10000
  } state_e;

  // States in which the controller owns the result and refuses new bytes
  function automatic logic is_busy(input state_e st);
    return (st == StExec) || (st == StWaitTx);
  endfunction

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte timeout counter: counts baud ticks while enabled, flags the expiring tick.
module frame_timeout
  import uart_alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned CNT_W         = TMR_W
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  input  logic i_tick,
  output logic o_expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Clear wins over counting; the owner clears on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && i_tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Expiry is the tick that would take the count past its last value.
  always_comb begin
    o_expired = i_enable && i_tick && (cnt_q == LAST);
  end

  // Counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode bytes from a UART receiver, launches the
// ALU result back through the transmitter, and guards against stalls and overruns.
module uart_alu_ctrl
  import uart_alu_pkg::*;
#(
  parameter int unsigned NB_DATA       = NB_DATA_DEF,
  parameter int unsigned NB_OP         = NB_OP_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  state_e             state_d, state_q;
  logic [NB_DATA-1:0] a_d, a_q;
  logic [NB_DATA-1:0] b_d, b_q;
  logic [NB_OP-1:0]   op_d, op_q;
  logic [NB_DATA-1:0] tx_data_d, tx_data_q;
  logic               tx_start_d, tx_start_q;
  logic               busy_d, busy_q;
  logic               timeout_d, timeout_q;
  logic               illegal;
  logic               tmr_clear;
  logic               tmr_enable;
  logic               tmr_expired;

  // Next-state and datapath capture; a received byte always beats a same-cycle expiry.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    tx_data_d = tx_data_q;
    timeout_d = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (i_rx_done_tick) begin
          a_d     = i_rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB: begin
        if (i_rx_done_tick) begin
          b_d     = i_rx_data;
          state_d = StWaitOp;
        end else if (tmr_expired) begin
          state_d   = StWaitA;
          timeout_d = 1'b1;
        end
      end
      StWaitOp: begin
        if (i_rx_done_tick) begin
          op_d    = i_rx_data[NB_OP-1:0];
          state_d = StExec;
        end else if (tmr_expired) begin
          state_d   = StWaitA;
          timeout_d = 1'b1;
        end
      end
      StExec: begin
        tx_data_d = i_alu_result;
        state_d   = StWaitTx;
      end
      StWaitTx: begin
        if (i_tx_done_tick) begin
          state_d = StWaitA;
        end
      end
      default: begin
        state_d = StWaitA;
        illegal = 1'b1;
      end
    endcase
  end

  // Registered status outputs track the state being entered.
  always_comb begin
    tx_start_d = (state_d == StExec);
    busy_d     = is_busy(state_d);
  end

  // Timer control; a byte dropped while busy clears an already-idle counter, which is harmless.
  always_comb begin
    tmr_clear  = i_rx_done_tick || (state_d != state_q) || illegal;
    tmr_enable = (state_q == StWaitB) || (state_q == StWaitOp);
  end

  // Dropped-byte flag must appear in the same cycle as the offending done tick.
  always_comb begin
    o_overrun = i_rx_done_tick && is_busy(state_q);
  end

  frame_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .CNT_W        (TMR_W)
  ) u_frame_timeout (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (tmr_clear),
    .i_enable (tmr_enable),
    .i_tick   (i_tick),
    .o_expired(tmr_expired)
  );

  // FSM state, operand/result registers and registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= StWaitA;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_alu_a    = a_q;
  assign o_alu_b    = b_q;
  assign o_alu_op   = op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed scenarios plus random traffic against a byte-count model.
module tb_uart_alu_ctrl;

  localparam int TO = 640;

  logic       clk;
  logic       i_reset;
  logic       i_tick;
  logic       i_rx_done_tick;
  logic [7:0] i_rx_data;
  logic [7:0] i_alu_result;
  logic       i_tx_done_tick;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_timeout;
  logic       o_overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: how many of the three bytes are held (0..2), or 3 = result launch cycle,
  // 4 = waiting for the transmitter.
  int         phase;
  int         idle;
  logic [7:0] m_a, m_b, m_tx;
  logic [5:0] m_op;
  bit         m_to;
  int         n_starts;

  uart_alu_ctrl dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_tick        (i_tick),
    .i_rx_done_tick(i_rx_done_tick),
    .i_rx_data     (i_rx_data),
    .i_alu_result  (i_alu_result),
    .i_tx_done_tick(i_tx_done_tick),
    .o_alu_a       (o_alu_a),
    .o_alu_b       (o_alu_b),
    .o_alu_op      (o_alu_op),
    .o_tx_start    (o_tx_start),
    .o_tx_data     (o_tx_data),
    .o_busy        (o_busy),
    .o_timeout     (o_timeout),
    .o_overrun     (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; idle = 0; m_a = 0; m_b = 0; m_op = 0; m_tx = 0; m_to = 0;
  endtask

  // One clock with the given inputs, checked against the model.
  task automatic step(input bit rx, input logic [7:0] d, input bit tk, input bit txd,
                      input logic [7:0] alu);
    i_rx_done_tick = rx; i_rx_data = d; i_tick = tk; i_tx_done_tick = txd; i_alu_result = alu;
    @(negedge clk);
    chk("overrun", {15'd0, o_overrun}, {15'd0, rx && phase >= 3});
    m_to = 0;
    case (phase)
      0: if (rx) begin m_a = d; phase = 1; idle = 0; end
      1, 2: begin
        if (rx) begin
          if (phase == 1) m_b = d; else m_op = d[5:0];
          phase++;
          idle = 0;
        end else if (tk) begin
          if (idle == TO - 1) begin phase = 0; idle = 0; m_to = 1; end
          else idle++;
        end
      end
      3: begin m_tx = alu; phase = 4; end
      default: if (txd) phase = 0;
    endcase
    @(posedge clk);
    #1;
    if (o_tx_start) n_starts++;
    chk("tx_start", {15'd0, o_tx_start}, {15'd0, phase == 3});
    chk("busy",     {15'd0, o_busy},     {15'd0, phase >= 3});
    chk("timeout",  {15'd0, o_timeout},  {15'd0, m_to});
    chk("alu_a",    {8'd0, o_alu_a},     {8'd0, m_a});
    chk("alu_b",    {8'd0, o_alu_b},     {8'd0, m_b});
    chk("alu_op",   {10'd0, o_alu_op},   {10'd0, m_op});
    chk("tx_data",  {8'd0, o_tx_data},   {8'd0, m_tx});
    i_rx_done_tick = 0; i_tick = 0; i_tx_done_tick = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] alu);
    step(1'b1, b, 1'b0, 1'b0, alu);
  endtask

  task automatic idle_cycles(input int n, input bit tk);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), tk, 1'b0, 8'($urandom));
  endtask

  // Reset held for one cycle with random activity on every input; all outputs must be 0.
  task automatic reset_cycle();
    i_reset = 1'b1;
    i_rx_done_tick = 1'($urandom); i_rx_data = 8'($urandom); i_tick = 1'($urandom);
    i_tx_done_tick = 1'($urandom); i_alu_result = 8'($urandom);
    @(negedge clk);
    chk("rst_outs", {o_alu_a, 2'b00, o_alu_op}, 16'd0);
    chk("rst_b_tx", {o_alu_b, o_tx_data}, 16'd0);
    chk("rst_flags", {12'd0, o_tx_start, o_busy, o_timeout, o_overrun}, 16'd0);
    @(posedge clk);
    #1;
    model_reset();
    i_rx_done_tick = 0; i_tick = 0; i_tx_done_tick = 0;
  endtask

  initial begin
    int starts_before;
    i_reset = 1'b1; i_tick = 0; i_rx_done_tick = 0; i_rx_data = 0;
    i_alu_result = 0; i_tx_done_tick = 0;
    n_starts = 0;
    model_reset();
    #1;
    reset_cycle();
    reset_cycle();
    i_reset = 1'b0;

    // Basic ADD transaction
    idle_cycles(2, 1'b1);
    send(8'h05, 8'h00);
    idle_cycles(3, 1'b1);
    send(8'h03, 8'h00);
    send(8'h20, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h08);
    chk("add_result", {8'd0, o_tx_data}, 16'h0008);
    idle_cycles(4, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Stall after operand A times out; then a clean transaction
    send(8'h05, 8'h00);
    idle_cycles(TO, 1'b1);
    chk("to_phase", 16'(phase), 16'd0);
    idle_cycles(5, 1'b1);
    send(8'h01, 8'h00);
    send(8'h02, 8'h00);
    send(8'h20, 8'h00);
    chk("a_after_to", {8'd0, o_alu_a}, 16'h0001);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h03);

    // Byte during transmit wait is dropped
    idle_cycles(2, 1'b1);
    send(8'hAA, 8'h00);
    chk("ovr_keep", {8'd0, o_tx_data}, 16'h0003);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Opcode byte on the very tick that would expire the timer
    send(8'h11, 8'h00);
    send(8'h22, 8'h00);
    idle_cycles(TO - 1, 1'b1);
    step(1'b1, 8'h3F, 1'b1, 1'b0, 8'h00);
    chk("race_exec", {15'd0, o_tx_start}, 16'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h5A);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);

    // Reset mid-sequence, then a single byte must not start anything
    send(8'h44, 8'h00);
    send(8'h55, 8'h00);
    reset_cycle();
    reset_cycle();
    i_reset = 1'b0;
    starts_before = n_starts;
    send(8'h77, 8'h00);
    idle_cycles(6, 1'b0);
    chk("no_start_rst", 16'(n_starts - starts_before), 16'd0);

    // Finish that sequence, then two back-to-back transactions
    send(8'h01, 8'h00);
    send(8'h02, 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0, 8'h10);
    step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    for (int t = 0; t < 2; t++) begin
      send(8'($urandom), 8'h00);
      send(8'($urandom), 8'h00);
      send(8'($urandom), 8'h00);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'($urandom));
      step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(1'b0, 8'h00, 1'b0, 1'b1, 8'h00);
    end
    chk("b2b_starts", 16'(n_starts - starts_before), 16'd3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
